fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program-counter register.
- Consumes the current PC, issues in-order requests to instruction memory, and pairs each returned instruction with its PC.
- Delivers {pc, instr} to decode over a valid/ready handshake.
- Computes the next PC (sequential or redirect) and drives the PC register's load enable, so the PC advances only when a fetch is accepted or a redirect occurs.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_stage_sync_fifo.sv | 66 ++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, the decode-bound entry type and PC arithmetic for the
// instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN_C   = 64;
    localparam int unsigned ILEN_C   = 32;
    localparam int unsigned PC_INC_C = 4;

    typedef struct packed {
        logic [XLEN_C-1:0] pc;
        logic [ILEN_C-1:0] instr;
    } fetch_entry_t;

    // Sequential successor PC; the add wraps modulo 2^XLEN.
    function automatic logic [XLEN_C-1:0] pc_inc(input logic [XLEN_C-1:0] pc);
        return pc + XLEN_C'(PC_INC_C);
    endfunction

endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Generic synchronous FIFO with registered storage, synchronous flush and an
// occupancy count; written data is visible at the head one cycle later.
module sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  T                 data_i,
    input  logic             pop_i,
    output T                 data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == DEPTH_C);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)      count_o <= count_o + 1'b1;
            else if (do_pop && !do_push) count_o <= count_o - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the count and pointers alone
    // decide which entries are meaningful, and unreset RAM maps to cheap cells.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues in-order memory requests for the current PC,
// pairs responses with their PCs and hands {pc, instr} to decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    // Must match the package widths carried by fetch_entry_t.
    parameter int unsigned XLEN            = XLEN_C,
    parameter int unsigned ILEN            = ILEN_C
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pc_ready_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [ILEN-1:0] if_instr_o,
    input  logic            id_ready_i
);

    localparam int unsigned      CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W:0]   MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] resp_count;
    logic [CNT_W-1:0] drop;
    logic             credit_ok;
    logic             grant;
    logic             rsp_ok;
    logic             rsp_keep;
    logic             pcq_empty;
    logic             pcq_full;
    logic             resp_empty;
    logic             resp_full;
    logic [XLEN-1:0]  rsp_pc;
    fetch_entry_t     rsp_entry;
    fetch_entry_t     head;

    // Outstanding requests are exactly the PCs waiting in the in-flight FIFO.
    sync_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (logic [XLEN-1:0]),
        .CNT_W (CNT_W)
    ) u_pc_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .flush_i  (1'b0),
        .push_i   (grant),
        .data_i   (pc_i),
        .pop_i    (rsp_ok),
        .data_o   (rsp_pc),
        .empty_o  (pcq_empty),
        .full_o   (pcq_full),
        .count_o  (outstanding)
    );

    sync_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (fetch_entry_t),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .flush_i  (redirect_i),
        .push_i   (rsp_keep),
        .data_i   (rsp_entry),
        .pop_i    (if_valid_o && id_ready_i),
        .data_o   (head),
        .empty_o  (resp_empty),
        .full_o   (resp_full),
        .count_o  (resp_count)
    );

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp_ok    = imem_rvalid_i && !pcq_empty;
    assign rsp_keep  = rsp_ok && !redirect_i && (drop == '0);
    assign rsp_entry = '{pc: rsp_pc, instr: imem_rdata_i};

    assign imem_addr_o = pc_i;
    assign if_valid_o  = !resp_empty;
    assign if_pc_o     = head.pc;
    assign if_instr_o  = head.instr;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pc_next_o  = pc_inc(pc_i);
        // Only issue when the response is guaranteed a slot in the buffer.
        credit_ok  = ({1'b0, outstanding} + {1'b0, resp_count}) < MAX_C;
        imem_req_o = reset_ni && !redirect_i && credit_ok && !resp_full && !pcq_full;
        grant      = imem_req_o && imem_gnt_i;
        pc_ready_o = reset_ni && (grant || redirect_i);
        if (reset_ni && redirect_i) pc_next_o = redirect_pc_i;
    end

    // Responses already in flight at a redirect belong to the old path.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            drop <= '0;
        end else if (redirect_i) begin
            drop <= outstanding - CNT_W'(rsp_ok);
        end else if (rsp_ok && (drop != '0)) begin
            drop <= drop - 1'b1;
        end
    end

    a_outstanding_max: assert property (@(posedge clk_i) disable iff (!reset_ni)
        {1'b0, outstanding} <= MAX_C);
    a_drop_le_outstanding: assert property (@(posedge clk_i) disable iff (!reset_ni)
        drop <= outstanding);
    a_pc_ready_cause: assert property (@(posedge clk_i) disable iff (!reset_ni)
        pc_ready_o |-> (grant || redirect_i));
    a_rvalid_in_flight: assert property (@(posedge clk_i) disable iff (!reset_ni)
        imem_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change on the falling edge and
// outputs are compared 1ns later, well clear of the rising edge.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [63:0] pc_i = 64'h0;
    logic [63:0] pc_next_o;
    logic        pc_ready_o;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'h0;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic [63:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        id_ready_i = 1'b0;

    logic [2:0]  flags;
    int          vectors = 0;
    int          miscompares = 0;

    assign flags = {imem_req_o, pc_ready_o, if_valid_o};

    always #5 clk_i = ~clk_i;

    fetch_stage dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .pc_i          (pc_i),
        .pc_next_o     (pc_next_o),
        .pc_ready_o    (pc_ready_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .id_ready_i    (id_ready_i)
    );

    // Instruction word the memory returns for a given fetch address.
    function automatic logic [31:0] mk_instr(input logic [63:0] addr);
        return {16'h1300, addr[15:0]};
    endfunction

    task automatic step(input logic [63:0] pc, input logic gnt, input logic rv,
                        input logic [63:0] rsp_addr, input logic rdy,
                        input logic redir, input logic [63:0] target);
        @(negedge clk_i);
        pc_i          = pc;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mk_instr(rsp_addr) : 32'h0;
        id_ready_i    = rdy;
        redirect_i    = redir;
        redirect_pc_i = target;
        #1;
    endtask

    task automatic do_reset(input logic [63:0] pc);
        @(negedge clk_i);
        reset_ni      = 1'b0;
        pc_i          = pc;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_ready_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 64'h0;
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    task automatic test_reset();
        pc_i = 64'h1000;
        #2;
        vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", flags); end
        vectors++; if (pc_next_o !== 64'h1004) begin miscompares++; $display("FAIL reset_pc_next: got %h want 1004", pc_next_o); end
        vectors++; if (imem_addr_o !== 64'h1000) begin miscompares++; $display("FAIL reset_addr: got %h want 1000", imem_addr_o); end
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    task automatic test_sequential();
        step(64'h1000, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL seq1_flags: got %b want 110", flags); end
        vectors++; if (pc_next_o !== 64'h1004) begin miscompares++; $display("FAIL seq1_pc_next: got %h want 1004", pc_next_o); end
        step(64'h1004, 1, 1, 64'h1000, 1, 0, 64'h0);
        vectors++; if (pc_next_o !== 64'h1008) begin miscompares++; $display("FAIL seq2_pc_next: got %h want 1008", pc_next_o); end
        step(64'h1008, 1, 1, 64'h1004, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b001) begin miscompares++; $display("FAIL seq3_flags: got %b want 001", flags); end
        vectors++; if (if_pc_o !== 64'h1000) begin miscompares++; $display("FAIL seq3_pc: got %h want 1000", if_pc_o); end
        vectors++; if (if_instr_o !== 32'h1300_1000) begin miscompares++; $display("FAIL seq3_instr: got %h want 13001000", if_instr_o); end
        step(64'h1008, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b111) begin miscompares++; $display("FAIL seq4_flags: got %b want 111", flags); end
        vectors++; if (if_pc_o !== 64'h1004) begin miscompares++; $display("FAIL seq4_pc: got %h want 1004", if_pc_o); end
        vectors++; if (pc_next_o !== 64'h100C) begin miscompares++; $display("FAIL seq4_pc_next: got %h want 100c", pc_next_o); end
        step(64'h100C, 0, 1, 64'h1008, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL seq5_flags: got %b want 100", flags); end
        step(64'h100C, 0, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (if_pc_o !== 64'h1008 || if_valid_o !== 1'b1) begin miscompares++; $display("FAIL seq6_pc: got %h/%b want 1008/1", if_pc_o, if_valid_o); end
    endtask

    task automatic test_stall();
        do_reset(64'h1000);
        step(64'h1000, 1, 0, 64'h0, 0, 0, 64'h0);
        step(64'h1004, 1, 1, 64'h1000, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL stall2_flags: got %b want 110", flags); end
        step(64'h1008, 1, 1, 64'h1004, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b001) begin miscompares++; $display("FAIL stall3_flags: got %b want 001", flags); end
        step(64'h1008, 1, 0, 64'h0, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b001) begin miscompares++; $display("FAIL stall4_flags: got %b want 001", flags); end
        vectors++; if (if_pc_o !== 64'h1000) begin miscompares++; $display("FAIL stall4_pc: got %h want 1000", if_pc_o); end
        step(64'h1008, 1, 0, 64'h0, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b001) begin miscompares++; $display("FAIL stall5_flags: got %b want 001", flags); end
        step(64'h1008, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (if_pc_o !== 64'h1000) begin miscompares++; $display("FAIL stall6_pc: got %h want 1000", if_pc_o); end
        step(64'h1008, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b111) begin miscompares++; $display("FAIL stall7_flags: got %b want 111", flags); end
        vectors++; if (if_pc_o !== 64'h1004) begin miscompares++; $display("FAIL stall7_pc: got %h want 1004", if_pc_o); end
        step(64'h100C, 1, 1, 64'h1008, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL stall8_flags: got %b want 110", flags); end
        step(64'h1010, 0, 1, 64'h100C, 1, 0, 64'h0);
        vectors++; if (if_pc_o !== 64'h1008 || if_instr_o !== 32'h1300_1008) begin miscompares++; $display("FAIL stall9_entry: got %h/%h want 1008/13001008", if_pc_o, if_instr_o); end
        step(64'h1010, 0, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b101) begin miscompares++; $display("FAIL stall10_flags: got %b want 101", flags); end
        vectors++; if (if_pc_o !== 64'h100C) begin miscompares++; $display("FAIL stall10_pc: got %h want 100c", if_pc_o); end
    endtask

    task automatic test_redirect();
        do_reset(64'h1000);
        step(64'h1000, 1, 0, 64'h0, 1, 0, 64'h0);
        step(64'h1004, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL redir2_flags: got %b want 110", flags); end
        step(64'h1008, 1, 0, 64'h0, 1, 1, 64'h2000);
        vectors++; if (flags !== 3'b010) begin miscompares++; $display("FAIL redir3_flags: got %b want 010", flags); end
        vectors++; if (pc_next_o !== 64'h2000) begin miscompares++; $display("FAIL redir3_pc_next: got %h want 2000", pc_next_o); end
        step(64'h2000, 1, 1, 64'h1000, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL redir4_flags: got %b want 000", flags); end
        step(64'h2000, 1, 1, 64'h1004, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL redir5_flags: got %b want 110", flags); end
        vectors++; if (pc_next_o !== 64'h2004) begin miscompares++; $display("FAIL redir5_pc_next: got %h want 2004", pc_next_o); end
        step(64'h2004, 0, 1, 64'h2000, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL redir6_flags: got %b want 100", flags); end
        step(64'h2004, 0, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b101) begin miscompares++; $display("FAIL redir7_flags: got %b want 101", flags); end
        vectors++; if (if_pc_o !== 64'h2000 || if_instr_o !== 32'h1300_2000) begin miscompares++; $display("FAIL redir7_entry: got %h/%h want 2000/13002000", if_pc_o, if_instr_o); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset(64'h1000);
        step(64'h1000, 1, 0, 64'h0, 0, 0, 64'h0);
        step(64'h1004, 0, 1, 64'h1000, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL rr2_flags: got %b want 100", flags); end
        step(64'h1004, 1, 0, 64'h0, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b111) begin miscompares++; $display("FAIL rr3_flags: got %b want 111", flags); end
        step(64'h1008, 1, 1, 64'h1004, 0, 1, 64'h2000);
        vectors++; if (flags !== 3'b011) begin miscompares++; $display("FAIL rr4_flags: got %b want 011", flags); end
        vectors++; if (pc_next_o !== 64'h2000) begin miscompares++; $display("FAIL rr4_pc_next: got %h want 2000", pc_next_o); end
        step(64'h2000, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL rr5_flags: got %b want 110", flags); end
        vectors++; if (imem_addr_o !== 64'h2000) begin miscompares++; $display("FAIL rr5_addr: got %h want 2000", imem_addr_o); end
        step(64'h2004, 0, 1, 64'h2000, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL rr6_flags: got %b want 100", flags); end
        step(64'h2004, 0, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 64'h2000) begin miscompares++; $display("FAIL rr7_entry: got %b/%h want 1/2000", if_valid_o, if_pc_o); end
    endtask

    task automatic test_pc_wrap();
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        step(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL wrap1_flags: got %b want 110", flags); end
        vectors++; if (pc_next_o !== 64'h0) begin miscompares++; $display("FAIL wrap1_pc_next: got %h want 0", pc_next_o); end
        step(64'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h0);
        vectors++; if (pc_next_o !== 64'h4) begin miscompares++; $display("FAIL wrap2_pc_next: got %h want 4", pc_next_o); end
        step(64'h0, 0, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (if_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC || if_instr_o !== 32'h1300_FFFC) begin miscompares++; $display("FAIL wrap3_entry: got %h/%h want fffffffffffffffc/1300fffc", if_pc_o, if_instr_o); end
    endtask

    task automatic test_reset_mid();
        do_reset(64'h1000);
        step(64'h1000, 1, 0, 64'h0, 0, 0, 64'h0);
        step(64'h1004, 1, 0, 64'h0, 0, 0, 64'h0);
        step(64'h1008, 1, 1, 64'h1000, 0, 0, 64'h0);
        vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL mid3_flags: got %b want 000", flags); end
        step(64'h1008, 1, 0, 64'h0, 0, 1, 64'h2000);
        vectors++; if (flags !== 3'b011) begin miscompares++; $display("FAIL mid4_flags: got %b want 011", flags); end
        reset_ni = 1'b0;
        #1;
        vectors++; if (flags !== 3'b000) begin miscompares++; $display("FAIL mid_async_flags: got %b want 000", flags); end
        vectors++; if (pc_next_o !== 64'h100C) begin miscompares++; $display("FAIL mid_async_pc_next: got %h want 100c", pc_next_o); end
        do_reset(64'h1000);
        step(64'h1000, 1, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b110) begin miscompares++; $display("FAIL restart1_flags: got %b want 110", flags); end
        step(64'h1004, 0, 1, 64'h1000, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b100) begin miscompares++; $display("FAIL restart2_flags: got %b want 100", flags); end
        step(64'h1004, 0, 0, 64'h0, 1, 0, 64'h0);
        vectors++; if (flags !== 3'b101) begin miscompares++; $display("FAIL restart3_flags: got %b want 101", flags); end
        vectors++; if (if_pc_o !== 64'h1000 || if_instr_o !== 32'h1300_1000) begin miscompares++; $display("FAIL restart3_entry: got %h/%h want 1000/13001000", if_pc_o, if_instr_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_rvalid();
        test_pc_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
